stream_pattern_master: RTL and testbench

STREAM_PATTERN_MASTER -- requirements
Module: stream_pattern_master

---
 rtl/stream_pattern_master.sv | 175 +++++++++++++++++
 tb/tb_stream_pattern_master.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/stream_pattern_master.sv
// AXI4-Stream pattern generator: emits frames of len+1 beats (increment, constant or LFSR pattern).
// Optional macro STREAM_PATTERN_LFSR_EN enables the LFSR pattern for mode 2; otherwise mode 2 increments.
module stream_pattern_master #(
    parameter int DATA_WIDTH        = 32,
    parameter int STORAGE_IDX_WIDTH = 10
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [STORAGE_IDX_WIDTH-1:0] len,
    input  logic [1:0]                   mode,
    input  logic [DATA_WIDTH-1:0]        base,
    output logic                         busy,
    output logic                         done,
    output logic [DATA_WIDTH-1:0]        M_AXI_TDATA,
    output logic [DATA_WIDTH/8-1:0]      M_AXI_TKEEP,
    output logic                         M_AXI_TVALID,
    input  logic                         M_AXI_TREADY,
    output logic                         M_AXI_TLAST
);

    localparam int KEEP_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t                         state_r, next_state_s;
    logic [STORAGE_IDX_WIDTH-1:0]   len_r, cnt_r, cnt_nx_s;
    logic [1:0]                     mode_r;
    logic [DATA_WIDTH-1:0]          base_r, data_r, seed_s;
    logic                           last_r, tvalid_r, busy_r, done_r;
    logic [KEEP_WIDTH-1:0]          keep_r;
    logic                           tvalid_nx_s, busy_nx_s, done_nx_s, handshake_s;

    // Mode 3 (reserved) and, without the LFSR build, mode 2 fall through to increment.
    function automatic logic [DATA_WIDTH-1:0] next_beat(input logic [DATA_WIDTH-1:0] cur,
                                                        input logic [1:0]            m,
                                                        input logic [DATA_WIDTH-1:0] b);
        case (m)
            2'd1:    next_beat = b;
`ifdef STREAM_PATTERN_LFSR_EN
            2'd2:    next_beat = {cur[DATA_WIDTH-2:0], cur[DATA_WIDTH-1] ^ cur[DATA_WIDTH-2]};
`endif
            default: next_beat = cur + DATA_WIDTH'(1);
        endcase
    endfunction

    assign handshake_s = tvalid_r & M_AXI_TREADY;
    assign cnt_nx_s    = cnt_r + STORAGE_IDX_WIDTH'(1);

    // First-beat value; an all-zero LFSR seed would lock up, so it becomes 1.
    always_comb begin
        seed_s = base;
`ifdef STREAM_PATTERN_LFSR_EN
        if ((mode == 2'd2) && (base == '0)) begin
            seed_s = DATA_WIDTH'(1);
        end else begin
            seed_s = base;
        end
`endif
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) next_state_s = ST_STREAM;
                else       next_state_s = ST_IDLE;
            end
            ST_STREAM: begin
                if (handshake_s && last_r) next_state_s = ST_DONE;
                else                       next_state_s = ST_STREAM;
            end
            ST_DONE: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Output decode from the next state so the control outputs come straight from flops.
    always_comb begin
        tvalid_nx_s = 1'b0;
        busy_nx_s   = 1'b0;
        done_nx_s   = 1'b0;
        case (next_state_s)
            ST_STREAM: begin
                tvalid_nx_s = 1'b1;
                busy_nx_s   = 1'b1;
            end
            ST_DONE: begin
                busy_nx_s = 1'b1;
                done_nx_s = 1'b1;
            end
            default: begin
                tvalid_nx_s = 1'b0;
                busy_nx_s   = 1'b0;
                done_nx_s   = 1'b0;
            end
        endcase
    end

    // Control output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tvalid_r <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            keep_r   <= '0;
        end else begin
            tvalid_r <= tvalid_nx_s;
            busy_r   <= busy_nx_s;
            done_r   <= done_nx_s;
            keep_r   <= {KEEP_WIDTH{tvalid_nx_s}};
        end
    end

    // Frame parameters, beat counter and current beat; all advance only on handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_r  <= '0;
            mode_r <= 2'd0;
            base_r <= '0;
            data_r <= '0;
            cnt_r  <= '0;
            last_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        len_r  <= len;
                        mode_r <= mode;
                        base_r <= seed_s;
                        data_r <= seed_s;
                        cnt_r  <= '0;
                        last_r <= (len == '0);
                    end
                end
                ST_STREAM: begin
                    if (handshake_s) begin
                        if (last_r) begin
                            last_r <= 1'b0;
                        end else begin
                            cnt_r  <= cnt_nx_s;
                            data_r <= next_beat(data_r, mode_r, base_r);
                            last_r <= (cnt_nx_s == len_r);
                        end
                    end
                end
                default: begin
                    last_r <= 1'b0;
                end
            endcase
        end
    end

    assign M_AXI_TDATA  = data_r;
    assign M_AXI_TKEEP  = keep_r;
    assign M_AXI_TVALID = tvalid_r;
    assign M_AXI_TLAST  = last_r;
    assign busy         = busy_r;
    assign done         = done_r;

endmodule

// File: tb/tb_stream_pattern_master.sv
// Scoreboard bench for stream_pattern_master: directed frames push expected beats, a monitor pops on handshake.
module tb_stream_pattern_master;

    localparam int DW = 32;
    localparam int IW = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [IW-1:0] len = '0;
    logic [1:0]    mode = 2'd0;
    logic [DW-1:0] base = '0;
    logic          busy, done;
    logic [DW-1:0] tdata;
    logic [3:0]    tkeep;
    logic          tvalid, tlast;
    logic          tready = 1'b0;

    int n_vec = 0;
    int n_err = 0;
    int done_cnt = 0;
    logic [DW:0] sb_q[$];

    stream_pattern_master #(.DATA_WIDTH(DW), .STORAGE_IDX_WIDTH(IW)) dut (
        .clk(clk), .reset(reset), .start(start), .len(len), .mode(mode), .base(base),
        .busy(busy), .done(done),
        .M_AXI_TDATA(tdata), .M_AXI_TKEEP(tkeep), .M_AXI_TVALID(tvalid),
        .M_AXI_TREADY(tready), .M_AXI_TLAST(tlast)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [DW-1:0] d, input logic l);
        sb_q.push_back({l, d});
    endtask

    function automatic logic rdy(input int pat, input int c);
        if (pat == 0) return 1'b1;
        else          return ((c - 1) % 3) == 0;
    endfunction

    // Monitor: compare every presented handshake beat against the scoreboard, and check stall stability.
    initial begin
        logic          stall_prev;
        logic [DW-1:0] data_prev;
        logic          last_prev;
        logic [DW:0]   exp_v;
        stall_prev = 1'b0;
        data_prev  = '0;
        last_prev  = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (done) done_cnt++;
                if (stall_prev) begin
                    check("stall_tvalid", tvalid, 1'b1);
                    check("stall_tdata", tdata, data_prev);
                    check("stall_tlast", tlast, last_prev);
                end
                if (tvalid && tready) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_beat", tvalid, 1'b0);
                    end else begin
                        exp_v = sb_q.pop_front();
                        check("beat_tdata", tdata, exp_v[DW-1:0]);
                        check("beat_tlast", tlast, exp_v[DW]);
                        check("beat_tkeep", tkeep, 4'hF);
                    end
                end
                stall_prev = tvalid && !tready;
                data_prev  = tdata;
                last_prev  = tlast;
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    task automatic run_frame(input logic [IW-1:0] l, input logic [1:0] m, input logic [DW-1:0] b,
                             input int hold, input int pat);
        int d0;
        d0 = done_cnt;
        @(posedge clk); #1;
        check("idle_tvalid", tvalid, 1'b0);
        len = l; mode = m; base = b; start = 1'b1;
        @(posedge clk); #1;
        check("latency_tvalid", tvalid, 1'b1);
        check("busy_in_frame", busy, 1'b1);
        len = ~l; mode = ~m; base = ~b;
        if (hold <= 1) start = 1'b0;
        for (int c = 1; c < 300 && done_cnt == d0; c++) begin
            tready = rdy(pat, c);
            if (c >= hold) start = 1'b0;
            @(posedge clk); #1;
        end
        start = 1'b0;
        tready = 1'b1;
        check("done_seen", done_cnt - d0, 1);
        repeat (4) @(posedge clk);
        #1;
        check("done_single_pulse", done_cnt - d0, 1);
        check("idle_busy", busy, 1'b0);
        check("idle_tvalid_after", tvalid, 1'b0);
        check("scoreboard_drained", sb_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int d0;
        #12;
        check("rst_tvalid", tvalid, 1'b0);
        check("rst_tlast", tlast, 1'b0);
        check("rst_tkeep", tkeep, 4'h0);
        check("rst_tdata", tdata, 32'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        // Incrementing frame, always ready.
        push(32'h10, 1'b0); push(32'h11, 1'b0); push(32'h12, 1'b0); push(32'h13, 1'b1);
        run_frame(10'd3, 2'd0, 32'h10, 1, 0);

        // Increment wraps at 2^32.
        push(32'hFFFFFFFE, 1'b0); push(32'hFFFFFFFF, 1'b0); push(32'h00000000, 1'b1);
        run_frame(10'd2, 2'd0, 32'hFFFFFFFE, 1, 0);

        // Constant pattern under back-pressure 1,0,0,1,...
        for (int i = 0; i < 5; i++) push(32'hA5A5A5A5, i == 4);
        run_frame(10'd4, 2'd1, 32'hA5A5A5A5, 1, 1);

        // LFSR with zero seed.
`ifdef STREAM_PATTERN_LFSR_EN
        push(32'h1, 1'b0); push(32'h2, 1'b0); push(32'h4, 1'b1);
`else
        push(32'h0, 1'b0); push(32'h1, 1'b0); push(32'h2, 1'b1);
`endif
        run_frame(10'd2, 2'd2, 32'h0, 1, 0);

        // Reserved mode behaves as increment.
        push(32'h7F, 1'b0); push(32'h80, 1'b1);
        run_frame(10'd1, 2'd3, 32'h7F, 1, 0);

        // Single-beat frame with start held through STREAM and DONE.
        push(32'hDEADBEEF, 1'b1);
        run_frame(10'd0, 2'd0, 32'hDEADBEEF, 3, 0);

        // Abort a len=7 frame after beat 2 has been accepted.
        push(32'h200, 1'b0); push(32'h201, 1'b0); push(32'h202, 1'b0);
        @(posedge clk); #1;
        len = 10'd7; mode = 2'd0; base = 32'h200; start = 1'b1; tready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 50 && sb_q.size() != 0; c++) begin
            @(negedge clk); #1;
        end
        check("abort_beats_seen", sb_q.size(), 0);
        d0 = done_cnt;
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        check("abort_tvalid", tvalid, 1'b0);
        check("abort_tlast", tlast, 1'b0);
        check("abort_tkeep", tkeep, 4'h0);
        check("abort_tdata", tdata, 32'h0);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk); #2;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_wait_idle", tvalid, 1'b0);
        for (int i = 0; i < 8; i++) push(32'h200 + i, i == 7);
        run_frame(10'd7, 2'd0, 32'h200, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
